alu_result_queue: RTL and testbench

Downstream stage for the `add_sub` datapath. Accepts each signed DATAW+1-bit add/sub result with its opcode, narrows it to DATAW bits with overflow detection and optional saturation, and buffers it in a small in-order FIFO. Results are presented to the consumer over a valid/ready handshake. The block decouples the combinational ALU from a consumer that may stall, and keeps a running count of overflowed results.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/alu_result_queue.sv | 105 ++++++++++
 tb/tb_alu_result_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, opcode encoding, and the
// result-narrowing helper used by alu_result_queue and the add_sub golden model.
package alu_pkg;

    localparam int unsigned DATAW = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    // Narrowed result: overflow flag plus DATAW-bit payload.
    typedef struct packed {
        logic             ovf;
        logic [DATAW-1:0] data;
    } narrow_t;

    // Narrow a DATAW+1-bit signed result to DATAW bits, clamping on overflow
    // when sat_en is set and wrapping otherwise.
    function automatic narrow_t narrow_sat(input logic [DATAW:0] result,
                                           input logic          sat_en);
        narrow_t r;
        r.ovf  = result[DATAW] ^ result[DATAW-1];
        r.data = result[DATAW-1:0];
        if (r.ovf && sat_en) begin
            r.data = result[DATAW] ? {1'b1, {(DATAW-1){1'b0}}}
                                   : {1'b0, {(DATAW-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: i_clk/i_reset (sync, active-high), i_push/i_wdata write side,
// i_pop read side, o_rdata head entry (raw storage), o_full/o_empty/o_count
// derived from the registered occupancy. Push while full and pop while empty
// are ignored. Storage is not reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/alu_result_queue.sv
// Narrows signed add_sub results to DATAW bits (overflow flag, optional
// saturation), buffers them in order, and presents them over valid/ready.
// Ports: i_clk/i_reset (sync, active-high); producer side i_valid/o_ready,
// i_result (DATAW+1 signed), i_op, i_sat_en; consumer side o_valid/i_ready,
// o_data/o_ovf/o_op (zero when empty); o_count occupancy; o_ovf_count
// saturating count of accepted overflowed results.
module alu_result_queue #(
    parameter int unsigned DATAW = alu_pkg::DATAW,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [DATAW:0]         i_result,
    input  logic                   i_op,
    input  logic                   i_sat_en,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATAW-1:0]       o_data,
    output logic                   o_ovf,
    output logic                   o_op,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [CNTW-1:0]        o_ovf_count
);

    localparam int unsigned EW = DATAW + 2;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             ovf_c;
    logic [DATAW-1:0] data_c;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;
    logic [CW-1:0]    count;
    logic [CNTW-1:0]  ovf_count_q, ovf_count_d;

    // Narrowing at accept time; the shared helper covers the default width.
    if (DATAW == alu_pkg::DATAW) begin : g_pkg_narrow
        alu_pkg::narrow_t narrowed;
        assign narrowed = alu_pkg::narrow_sat(i_result, i_sat_en);
        assign ovf_c    = narrowed.ovf;
        assign data_c   = narrowed.data;
    end else begin : g_local_narrow
        always_comb begin
            ovf_c  = i_result[DATAW] ^ i_result[DATAW-1];
            data_c = i_result[DATAW-1:0];
            if (ovf_c && i_sat_en) begin
                data_c = i_result[DATAW] ? {1'b1, {(DATAW-1){1'b0}}}
                                         : {1'b0, {(DATAW-1){1'b1}}};
            end
        end
    end

    // Handshakes depend only on registered occupancy (plus reset on ready).
    assign o_ready = !full && !i_reset;
    assign o_valid = !empty;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign wdata   = {i_op, ovf_c, data_c};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_wdata (wdata),
        .i_pop   (pop),
        .o_rdata (rdata),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    // Head fields are masked so stale storage never leaks when empty.
    assign o_data  = o_valid ? rdata[DATAW-1:0] : '0;
    assign o_ovf   = o_valid & rdata[DATAW];
    assign o_op    = o_valid & rdata[DATAW+1];
    assign o_count = count;

    // Overflow event counter, holding at all-ones.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (push && ovf_c && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign o_ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed cases with literal
// expectations, then randomized add_sub traffic against a queue-based model.
module tb_alu_result_queue;

    localparam int DATAW = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    logic             clk;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [DATAW:0]   i_result;
    logic             i_op;
    logic             i_sat_en;
    logic             o_valid;
    logic             i_ready;
    logic [DATAW-1:0] o_data;
    logic             o_ovf;
    logic             o_op;
    logic [2:0]       o_count;
    logic [CNTW-1:0]  o_ovf_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_result_queue #(.DATAW(DATAW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result    (i_result),
        .i_op        (i_op),
        .i_sat_en    (i_sat_en),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_ovf       (o_ovf),
        .o_op        (o_op),
        .o_count     (o_count),
        .o_ovf_count (o_ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference narrowing from the value's numeric range.
    function automatic logic [9:0] ref_entry(input logic [8:0] r, input logic sat, input logic op);
        int v;
        int d;
        logic ovf;
        v   = int'($signed(r));
        ovf = (v > 127) || (v < -128);
        d   = v;
        if (ovf && sat) d = (v > 0) ? 127 : -128;
        return {op, ovf, 8'(d)};
    endfunction

    // Behavioural model: a queue of {op, ovf, data} plus a saturating counter.
    logic [9:0] mq[$];
    int         m_ovf_cnt  = 0;
    bit         model_init = 0;
    int         n_acc      = 0;

    always @(posedge clk) begin
        logic [9:0] e;
        bit do_pop;
        bit do_push;
        if (i_reset) begin
            mq.delete();
            m_ovf_cnt  = 0;
            model_init = 1;
        end else if (model_init) begin
            do_pop  = (mq.size() > 0) && i_ready;
            do_push = i_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e = ref_entry(i_result, i_sat_en, i_op);
                mq.push_back(e);
                if (e[8] && m_ovf_cnt < 65535) m_ovf_cnt++;
                n_acc++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [9:0] h;
        if (model_init) begin
            h = (mq.size() > 0) ? mq[0] : 10'd0;
            check("m_valid",  32'(o_valid),     32'(mq.size() > 0));
            check("m_ready",  32'(o_ready),     32'(!i_reset && mq.size() < DEPTH));
            check("m_count",  32'(o_count),     32'(mq.size()));
            check("m_ovfcnt", 32'(o_ovf_count), 32'(m_ovf_cnt));
            check("m_data",   32'(o_data),      32'(h[7:0]));
            check("m_ovf",    32'(o_ovf),       32'(h[8]));
            check("m_op",     32'(o_op),        32'(h[9]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [8:0] r, input logic sat, input logic op);
        i_valid  = 1'b1;
        i_result = r;
        i_sat_en = sat;
        i_op     = op;
        tick();
        i_valid  = 1'b0;
    endtask

    task automatic expect_pop(input string name, input logic [7:0] d, input logic ovf, input logic op);
        check({name, "_valid"}, 32'(o_valid), 32'd1);
        check({name, "_data"},  32'(o_data),  32'(d));
        check({name, "_ovf"},   32'(o_ovf),   32'(ovf));
        check({name, "_op"},    32'(o_op),    32'(op));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [8:0] r;
        int         acc0;
        int         cyc;

        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_result = '0;
        i_op     = 1'b0;
        i_sat_en = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        check("rst_valid",  32'(o_valid),     32'd0);
        check("rst_ready",  32'(o_ready),     32'd1);
        check("rst_count",  32'(o_count),     32'd0);
        check("rst_ovfcnt", 32'(o_ovf_count), 32'd0);
        check("rst_data",   32'(o_data),      32'd0);

        // Narrowing and saturation
        push1(9'h07F, 1'b1, 1'b0);
        push1(9'h0FE, 1'b1, 1'b0);
        push1(9'h0FE, 1'b0, 1'b0);
        push1(9'h100, 1'b1, 1'b0);
        check("nar_ovfcnt", 32'(o_ovf_count), 32'd3);
        check("nar_count",  32'(o_count),     32'd4);
        check("nar_ready",  32'(o_ready),     32'd0);
        expect_pop("nar0", 8'h7F, 1'b0, 1'b0);
        expect_pop("nar1", 8'h7F, 1'b1, 1'b0);
        expect_pop("nar2", 8'hFE, 1'b1, 1'b0);
        expect_pop("nar3", 8'h80, 1'b1, 1'b0);

        // Fill and backpressure
        for (int v = 1; v <= 4; v++) push1(9'(v), 1'b0, 1'b1);
        check("full_ready", 32'(o_ready), 32'd0);
        i_valid  = 1'b1;
        i_result = 9'd5;
        i_op     = 1'b1;
        tick();
        check("full_hold_count", 32'(o_count), 32'd4);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("full_pop_ready", 32'(o_ready), 32'd1);
        check("full_pop_count", 32'(o_count), 32'd3);
        tick();
        i_valid = 1'b0;
        check("full_acc_count", 32'(o_count), 32'd4);
        for (int v = 2; v <= 5; v++) expect_pop("drain", 8'(v), 1'b0, 1'b1);

        // Simultaneous push and pop at count 2
        push1(9'd10, 1'b0, 1'b0);
        push1(9'd11, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            i_valid  = 1'b1;
            i_result = 9'(12 + k);
            i_ready  = 1'b1;
            check("pp_head", 32'(o_data), 32'(10 + k));
            tick();
            check("pp_count", 32'(o_count), 32'd2);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        expect_pop("pp_d0", 8'd13, 1'b0, 1'b0);
        expect_pop("pp_d1", 8'd14, 1'b0, 1'b0);

        // Reset mid-operation with a push in flight
        push1(9'd20, 1'b0, 1'b0);
        push1(9'd21, 1'b0, 1'b0);
        push1(9'h0F0, 1'b0, 1'b0);
        check("mid_pre_count", 32'(o_count), 32'd3);
        i_valid  = 1'b1;
        i_result = 9'd23;
        i_reset  = 1'b1;
        tick();
        i_reset = 1'b0;
        i_valid = 1'b0;
        #1;
        check("mid_count",  32'(o_count),     32'd0);
        check("mid_valid",  32'(o_valid),     32'd0);
        check("mid_ovfcnt", 32'(o_ovf_count), 32'd0);
        check("mid_ready",  32'(o_ready),     32'd1);

        // Randomized add_sub traffic
        acc0 = n_acc;
        cyc  = 0;
        while ((n_acc - acc0) < 1000 && cyc < 8000) begin
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            op       = 1'($urandom_range(0, 1));
            r        = op ? ({a[7], a} - {b[7], b}) : ({a[7], a} + {b[7], b});
            i_result = r;
            i_op     = op;
            i_sat_en = 1'($urandom_range(0, 1));
            i_valid  = ($urandom_range(0, 9) < 7);
            i_ready  = ($urandom_range(0, 9) < 6);
            tick();
            cyc++;
        end
        check("rand_budget", 32'(n_acc - acc0 >= 1000), 32'd1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) tick();
        check("rand_drained", 32'(o_count), 32'd0);
        i_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
